// File: rtl/cond_issue_ctrl.sv
// -----------------------------------------------------------------------------
// cond_issue_ctrl
//
// Single-entry conditional-execution stage for an ARM-style pipeline. One
// instruction at a time is taken from upstream, held until the NZCV flags it
// depends on are architecturally settled, evaluated against the registered
// status register, and then presented downstream with an execute/annul verdict.
//
// Flag-setting instructions that execute are counted as "pending" from the
// moment they leave this stage until the ALU writes their flags back. A new
// conditional instruction may only be evaluated once nothing is pending and no
// writeback is landing this cycle. Unconditional (AL) instructions skip that
// wait. Flag-setting instructions additionally need a free pending slot.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   in_valid       upstream instruction present
//   in_cond[3:0]   ARM condition field of the upstream instruction
//   in_sets_flags  upstream instruction has its S bit set
//   in_ready       this stage accepts the upstream instruction this cycle
//   alu_flag_we    ALU writes back new NZCV this cycle
//   alu_flags[3:0] new flags {N,Z,C,V}
//   out_valid      evaluated instruction present downstream
//   out_exec       condition passed; instruction shall execute
//   out_sets_flags held S bit gated by out_exec
//   out_ready      downstream accepts the instruction this cycle
//   status[3:0]    architectural NZCV register
//   pending_cnt    issued flag writers not yet written back
//   flag_err       sticky: flag writeback arrived with nothing pending
//   wait_cycles    saturating count of cycles spent stalled in WAIT
//
// Parameter
//   MAX_PENDING    maximum in-flight flag writers, legal range 1..3
// -----------------------------------------------------------------------------
module cond_issue_ctrl #(
    parameter int unsigned MAX_PENDING = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  in_cond,
    input  logic        in_sets_flags,
    output logic        in_ready,
    input  logic        alu_flag_we,
    input  logic [3:0]  alu_flags,
    output logic        out_valid,
    output logic        out_exec,
    output logic        out_sets_flags,
    input  logic        out_ready,
    output logic [3:0]  status,
    output logic [1:0]  pending_cnt,
    output logic        flag_err,
    output logic [15:0] wait_cycles
);

    localparam logic [1:0] MAX_PEND = 2'(MAX_PENDING);
    localparam logic [3:0] COND_AL  = 4'b1110;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t      state_q;
    logic [3:0]  cond_q;        // condition of the held instruction
    logic        sets_q;        // S bit of the held instruction
    logic        out_valid_q;
    logic        out_exec_q;
    logic        out_sets_q;
    logic [3:0]  status_q;
    logic [1:0]  pending_q;
    logic        flag_err_q;
    logic [15:0] wait_q;

    // Next-state values for the flag/credit bookkeeping
    logic [3:0]  status_d;
    logic [1:0]  pending_d;
    logic        flag_err_d;
    logic [15:0] wait_d;

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    logic transfer;
    logic issue;

    // A FULL slot frees itself in the same cycle it is consumed, so upstream
    // may refill it then; WAIT never accepts because the slot is occupied.
    assign in_ready = !rst && ((state_q == ST_EMPTY) ||
                               ((state_q == ST_FULL) && out_ready));
    assign transfer = in_valid && in_ready;

    // An executing flag-setter leaving the stage becomes an in-flight writer.
    assign issue = (state_q == ST_FULL) && out_ready && out_sets_q;

    // -------------------------------------------------------------------------
    // Condition evaluation against the registered flags
    // -------------------------------------------------------------------------
    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;
    logic cond_pass;

    assign {flag_n, flag_z, flag_c, flag_v} = status_q;

    always_comb begin
        cond_pass = 1'b0;
        case (cond_q)
            4'b0000: cond_pass = flag_z;                              // EQ
            4'b0001: cond_pass = !flag_z;                             // NE
            4'b0010: cond_pass = flag_c;                              // CS
            4'b0011: cond_pass = !flag_c;                             // CC
            4'b0100: cond_pass = flag_n;                              // MI
            4'b0101: cond_pass = !flag_n;                             // PL
            4'b0110: cond_pass = flag_v;                              // VS
            4'b0111: cond_pass = !flag_v;                             // VC
            4'b1000: cond_pass = flag_c && !flag_z;                   // HI
            4'b1001: cond_pass = !flag_c || flag_z;                   // LS
            4'b1010: cond_pass = (flag_n == flag_v);                  // GE
            4'b1011: cond_pass = (flag_n != flag_v);                  // LT
            4'b1100: cond_pass = !flag_z && (flag_n == flag_v);       // GT
            4'b1101: cond_pass = flag_z || (flag_n != flag_v);        // LE
            4'b1110: cond_pass = 1'b1;                                // AL
            default: cond_pass = 1'b0;                                // NV
        endcase
    end

    // -------------------------------------------------------------------------
    // Evaluation gate
    // -------------------------------------------------------------------------
    // The flags are only trustworthy when no writer is in flight and none is
    // landing this cycle (status_q would be stale by one cycle). AL does not
    // look at the flags, so it never has to wait for them.
    logic flags_settled;
    logic credit_ok;
    logic can_eval;

    assign flags_settled = (cond_q == COND_AL) ||
                           ((pending_q == 2'd0) && !alu_flag_we);
    // Uses the current count: a writeback landing this cycle frees its slot
    // only from the next cycle on.
    assign credit_ok     = !sets_q || (pending_q < MAX_PEND);
    assign can_eval      = (state_q == ST_WAIT) && flags_settled && credit_ok;

    // -------------------------------------------------------------------------
    // Flag register, pending counter, error flag, stall counter
    // -------------------------------------------------------------------------
    always_comb begin
        status_d   = status_q;
        pending_d  = pending_q;
        flag_err_d = flag_err_q;

        if (alu_flag_we) begin
            status_d = alu_flags;
            // A simultaneous issue replaces the retiring writer one-for-one.
            if (!issue) begin
                if (pending_q != 2'd0) begin
                    pending_d = pending_q - 2'd1;
                end else begin
                    flag_err_d = 1'b1;
                end
            end
        end else if (issue) begin
            pending_d = pending_q + 2'd1;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if ((state_q == ST_WAIT) && !can_eval && (wait_q != 16'hFFFF)) begin
            wait_d = wait_q + 16'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            cond_q      <= 4'b0000;
            sets_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_exec_q  <= 1'b0;
            out_sets_q  <= 1'b0;
            status_q    <= 4'b0000;
            pending_q   <= 2'd0;
            flag_err_q  <= 1'b0;
            wait_q      <= 16'd0;
        end else begin
            status_q   <= status_d;
            pending_q  <= pending_d;
            flag_err_q <= flag_err_d;
            wait_q     <= wait_d;

            case (state_q)
                ST_EMPTY: begin
                    if (transfer) begin
                        cond_q  <= in_cond;
                        sets_q  <= in_sets_flags;
                        state_q <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (can_eval) begin
                        out_valid_q <= 1'b1;
                        out_exec_q  <= cond_pass;
                        out_sets_q  <= sets_q && cond_pass;
                        state_q     <= ST_FULL;
                    end
                end

                ST_FULL: begin
                    // Without out_ready every output register simply holds.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_exec_q  <= 1'b0;
                        out_sets_q  <= 1'b0;
                        if (transfer) begin
                            cond_q  <= in_cond;
                            sets_q  <= in_sets_flags;
                            state_q <= ST_WAIT;
                        end else begin
                            state_q <= ST_EMPTY;
                        end
                    end
                end

                default: begin
                    state_q <= ST_EMPTY;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_valid      = out_valid_q;
    assign out_exec       = out_exec_q;
    assign out_sets_flags = out_sets_q;
    assign status         = status_q;
    assign pending_cnt    = pending_q;
    assign flag_err       = flag_err_q;
    assign wait_cycles    = wait_q;

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cond_issue_ctrl
//
// Drives cond_issue_ctrl with directed scenarios followed by randomized
// traffic. A behavioural model (a one-entry instruction queue plus flag,
// credit and error bookkeeping, with the ARM condition rule written as
// "base test per pair, odd code inverts") predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_cond_issue_ctrl;

    localparam int MAXP = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_cond;
    logic        in_sets_flags;
    logic        in_ready;
    logic        alu_flag_we;
    logic [3:0]  alu_flags;
    logic        out_valid;
    logic        out_exec;
    logic        out_sets_flags;
    logic        out_ready;
    logic [3:0]  status;
    logic [1:0]  pending_cnt;
    logic        flag_err;
    logic [15:0] wait_cycles;

    always #5 clk = ~clk;

    cond_issue_ctrl #(
        .MAX_PENDING(MAXP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_cond       (in_cond),
        .in_sets_flags (in_sets_flags),
        .in_ready      (in_ready),
        .alu_flag_we   (alu_flag_we),
        .alu_flags     (alu_flags),
        .out_valid     (out_valid),
        .out_exec      (out_exec),
        .out_sets_flags(out_sets_flags),
        .out_ready     (out_ready),
        .status        (status),
        .pending_cnt   (pending_cnt),
        .flag_err      (flag_err),
        .wait_cycles   (wait_cycles)
    );

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, required %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic [3:0] cond;
        logic       s;
        logic       evald;
        logic       exec;
    } inst_t;

    inst_t      m_q[$];        // at most one held instruction
    logic [3:0] m_status  = 4'd0;
    int         m_pending = 0;
    bit         m_err     = 1'b0;
    int         m_wait    = 0;
    bit         m_xfer    = 1'b0;
    bit         m_rst_seen = 1'b0;

    // ARM rule: codes come in pairs, the even code tests a base predicate and
    // the odd code tests its inverse; 1111 never executes here.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        logic [2:0] pair;
        {n, z, cf, v} = f;
        pair = c[3:1];
        case (pair)
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? ~base : base;
    endfunction

    function automatic bit model_ready();
        if (rst !== 1'b0) return 1'b0;
        if (m_q.size() == 0) return 1'b1;
        return m_q[0].evald && (out_ready === 1'b1);
    endfunction

    task automatic model_step();
        inst_t h;
        inst_t nw;
        bit    ready;
        bit    issue;
        bit    can;
        m_rst_seen = (rst === 1'b1);
        if (m_rst_seen) begin
            m_q.delete();
            m_status  = 4'd0;
            m_pending = 0;
            m_err     = 1'b0;
            m_wait    = 0;
            m_xfer    = 1'b0;
            return;
        end
        ready  = model_ready();
        m_xfer = (in_valid === 1'b1) && ready;
        issue  = 1'b0;
        if (m_q.size() != 0) begin
            h = m_q[0];
            if (!h.evald) begin
                can = (h.cond == 4'hE) || (m_pending == 0 && alu_flag_we !== 1'b1);
                if (h.s && m_pending >= MAXP) can = 1'b0;
                if (can) begin
                    h.evald = 1'b1;
                    h.exec  = ref_cond(h.cond, m_status);
                    m_q[0]  = h;
                end else if (m_wait < 65535) begin
                    m_wait++;
                end
            end else if (out_ready === 1'b1) begin
                issue = h.s && h.exec;
                void'(m_q.pop_front());
            end
        end
        if (m_xfer) begin
            nw.cond  = in_cond;
            nw.s     = in_sets_flags;
            nw.evald = 1'b0;
            nw.exec  = 1'b0;
            m_q.push_back(nw);
        end
        if (alu_flag_we === 1'b1) begin
            m_status = alu_flags;
            if (!issue) begin
                if (m_pending > 0) m_pending--;
                else m_err = 1'b1;
            end
        end else if (issue) begin
            m_pending++;
        end
    endtask

    // One clock: check the combinational ready, advance the model, then
    // compare every registered output just after the edge.
    task automatic cycle();
        bit v;
        bit e;
        bit s;
        #1;
        check_val("in_ready", 32'(in_ready), 32'(model_ready()));
        model_step();
        @(posedge clk);
        #1;
        v = 1'b0;
        e = 1'b0;
        s = 1'b0;
        if (m_q.size() != 0) begin
            v = m_q[0].evald;
            e = m_q[0].exec;
            s = m_q[0].s;
        end
        check_val("out_valid", 32'(out_valid), 32'(v));
        if (v) begin
            check_val("out_exec", 32'(out_exec), 32'(e));
            check_val("out_sets_flags", 32'(out_sets_flags), 32'(s & e));
        end
        if (m_rst_seen) begin
            check_val("rst_out_exec", 32'(out_exec), 32'd0);
            check_val("rst_out_sets_flags", 32'(out_sets_flags), 32'd0);
        end
        check_val("status", 32'(status), 32'(m_status));
        check_val("pending_cnt", 32'(pending_cnt), 32'(m_pending));
        check_val("flag_err", 32'(flag_err), 32'(m_err));
        check_val("wait_cycles", 32'(wait_cycles), 32'(m_wait));
    endtask

    // Offer one instruction until it is accepted (bounded).
    task automatic send(input logic [3:0] c, input logic s);
        int budget;
        budget        = 0;
        in_valid      = 1'b1;
        in_cond       = c;
        in_sets_flags = s;
        do begin
            cycle();
            budget++;
        end while (!m_xfer && budget < 50);
        in_valid = 1'b0;
        check_val("send_accepted", 32'(m_xfer), 32'd1);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_cond       = 4'h0;
        in_sets_flags = 1'b0;
        alu_flag_we   = 1'b0;
        alu_flags     = 4'h0;
        out_ready     = 1'b1;

        // Reset state
        cycle();
        cycle();
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_status", 32'(status), 32'd0);
        check_val("rst_pending", 32'(pending_cnt), 32'd0);
        check_val("rst_flag_err", 32'(flag_err), 32'd0);
        check_val("rst_wait", 32'(wait_cycles), 32'd0);
        rst = 1'b0;

        // EQ with Z=0: two-cycle latency, annulled, no credit consumed
        send(4'h0, 1'b0);
        check_val("lat1_valid", 32'(out_valid), 32'd0);
        cycle();
        check_val("lat2_valid", 32'(out_valid), 32'd1);
        check_val("eq_exec", 32'(out_exec), 32'd0);
        check_val("eq_pending", 32'(pending_cnt), 32'd0);
        cycle();

        // Flag writer issues, dependent EQ stalls until writeback
        send(4'hE, 1'b1);
        cycle();
        check_val("al_exec", 32'(out_exec), 32'd1);
        check_val("al_sets", 32'(out_sets_flags), 32'd1);
        cycle();
        check_val("issue_pending", 32'(pending_cnt), 32'd1);
        send(4'h0, 1'b0);
        repeat (4) cycle();
        check_val("stall_valid", 32'(out_valid), 32'd0);
        check_val("stall_wait4", 32'(wait_cycles), 32'd4);
        alu_flag_we = 1'b1;
        alu_flags   = 4'b0100;
        cycle();
        alu_flag_we = 1'b0;
        check_val("wb_status", 32'(status), 32'b0100);
        check_val("wb_pending", 32'(pending_cnt), 32'd0);
        check_val("wb_valid", 32'(out_valid), 32'd0);
        cycle();
        check_val("dep_valid", 32'(out_valid), 32'd1);
        check_val("dep_exec", 32'(out_exec), 32'd1);
        check_val("dep_wait5", 32'(wait_cycles), 32'd5);
        cycle();

        // Credit limit
        alu_flags = 4'b0000;
        repeat (3) begin
            send(4'hE, 1'b1);
            cycle();
        end
        cycle();
        check_val("max_pending3", 32'(pending_cnt), 32'd3);
        send(4'hE, 1'b1);
        repeat (3) cycle();
        check_val("max_hold_valid", 32'(out_valid), 32'd0);
        alu_flag_we = 1'b1;
        cycle();
        alu_flag_we = 1'b0;
        check_val("max_after_wb", 32'(pending_cnt), 32'd2);
        cycle();
        check_val("max_released", 32'(out_valid), 32'd1);
        cycle();
        check_val("max_back_to3", 32'(pending_cnt), 32'd3);

        // Issue coinciding with writeback; stray writeback sets the error
        alu_flag_we = 1'b1;
        repeat (3) cycle();
        alu_flag_we = 1'b0;
        check_val("drained", 32'(pending_cnt), 32'd0);
        send(4'hE, 1'b1);
        cycle();
        cycle();
        send(4'hE, 1'b1);
        cycle();
        alu_flag_we = 1'b1;
        alu_flags   = 4'b1010;
        cycle();
        alu_flag_we = 1'b0;
        check_val("same_cycle_pending", 32'(pending_cnt), 32'd1);
        check_val("same_cycle_status", 32'(status), 32'b1010);
        check_val("same_cycle_err", 32'(flag_err), 32'd0);
        alu_flag_we = 1'b1;
        alu_flags   = 4'b0011;
        cycle();
        check_val("last_wb_pending", 32'(pending_cnt), 32'd0);
        check_val("last_wb_err", 32'(flag_err), 32'd0);
        cycle();
        alu_flag_we = 1'b0;
        check_val("stray_wb_err", 32'(flag_err), 32'd1);
        cycle();
        check_val("err_sticky", 32'(flag_err), 32'd1);

        // Downstream back-pressure in FULL
        send(4'hE, 1'b0);
        cycle();
        out_ready     = 1'b0;
        in_valid      = 1'b1;
        in_cond       = 4'h1;
        in_sets_flags = 1'b0;
        repeat (3) begin
            cycle();
            check_val("bp_valid", 32'(out_valid), 32'd1);
            check_val("bp_exec", 32'(out_exec), 32'd1);
            check_val("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();

        // Full condition x flags sweep
        for (int st = 0; st < 16; st++) begin
            alu_flag_we = 1'b1;
            alu_flags   = 4'(st);
            cycle();
            alu_flag_we = 1'b0;
            for (int c = 0; c < 16; c++) begin
                send(4'(c), 1'b0);
                cycle();
                check_val($sformatf("sweep c=%0d st=%0d", c, st), 32'(out_exec),
                          32'(ref_cond(4'(c), 4'(st))));
            end
            cycle();
        end

        // Reset mid-WAIT, then mid-FULL
        send(4'hE, 1'b1);
        cycle();
        cycle();
        send(4'h0, 1'b0);
        cycle();
        check_val("pre_rst_pending", 32'(pending_cnt), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_val("rst_wait_valid", 32'(out_valid), 32'd0);
        check_val("rst_wait_pending", 32'(pending_cnt), 32'd0);
        check_val("rst_wait_err", 32'(flag_err), 32'd0);
        send(4'hE, 1'b0);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_val("rst_full_valid", 32'(out_valid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 199) == 0);
            in_valid      = 1'($urandom_range(0, 1));
            in_cond       = 4'($urandom);
            in_sets_flags = 1'($urandom_range(0, 1));
            out_ready     = ($urandom_range(0, 3) != 0);
            alu_flag_we   = ($urandom_range(0, 5) == 0);
            alu_flags     = 4'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cond_issue_ctrl.md
COND_ISSUE_CTRL -- requirements
Module: cond_issue_ctrl

Interface
REQ-001 Parameter MAX_PENDING, default 3, SHALL set the maximum number of issued flag-setting instructions awaiting ALU flag writeback (range 1..3).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  upstream instruction present.
REQ-005 in_cond  input  4  ARM condition field of the upstream instruction.
REQ-006 in_sets_flags  input  1  upstream instruction has the S bit set.
REQ-007 in_ready  output  1  block accepts the upstream instruction this cycle.
REQ-008 alu_flag_we  input  1  ALU writes back new NZCV this cycle.
REQ-009 alu_flags  input  4  new flags {N,Z,C,V}.
REQ-010 out_valid  output  1  evaluated instruction present downstream.
REQ-011 out_exec  output  1  condition passed; instruction shall execute.
REQ-012 out_sets_flags  output  1  held S bit, gated: SHALL equal held S AND out_exec.
REQ-013 out_ready  input  1  downstream accepts the instruction this cycle.
REQ-014 status  output  4  current architectural NZCV register.
REQ-015 pending_cnt  output  2  issued flag writers not yet written back.
REQ-016 flag_err  output  1  sticky: flag writeback arrived with none pending.
REQ-017 wait_cycles  output  16  saturating count of cycles spent in WAIT.

Function
REQ-018 A 3-state FSM SHALL control flow: EMPTY, WAIT (instruction held, not yet evaluated), FULL (evaluated result on outputs).
REQ-019 Transfer SHALL occur only when in_valid=1 and in_ready=1; in_ready SHALL be 1 in EMPTY, equal out_ready in FULL, and 0 in WAIT and while rst=1.
REQ-020 EMPTY: on transfer, capture in_cond and in_sets_flags and go to WAIT; otherwise stay.
REQ-021 WAIT: the instruction SHALL be evaluated when (in_cond=1110) or (pending_cnt=0 and alu_flag_we=0); additionally, if held S=1, evaluation SHALL require pending_cnt<MAX_PENDING. On evaluation, register out_exec and go to FULL; otherwise stay and increment wait_cycles (saturate at 0xFFFF).
REQ-022 Evaluation SHALL use the registered status: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 SHALL give 0.
REQ-023 FULL: out_valid=1; if out_ready=0, hold all outputs stable; if out_ready=1 and transfer, go to WAIT with new capture; if out_ready=1 and no transfer, go to EMPTY.
REQ-024 Issue SHALL be defined as FULL and out_ready=1 and out_sets_flags=1; issue SHALL increment pending_cnt.
REQ-025 alu_flag_we=1 SHALL load status<=alu_flags next cycle and decrement pending_cnt if nonzero.
REQ-026 Issue and alu_flag_we in the same cycle SHALL leave pending_cnt unchanged and still load status.
REQ-027 alu_flag_we=1 with pending_cnt=0 and no same-cycle issue SHALL load status, keep pending_cnt=0, set flag_err=1 until reset.
REQ-028 Minimum latency transfer->out_valid SHALL be 2 cycles; back-to-back sustained throughput SHALL be one instruction per 2 cycles.
REQ-029 Failed-condition instructions SHALL still be presented (out_valid=1, out_exec=0) and SHALL NOT increment pending_cnt.

Reset
REQ-030 While rst=1 at a clock edge: state EMPTY, status=0000, pending_cnt=0, out_valid=0, out_exec=0, out_sets_flags=0, flag_err=0, wait_cycles=0; any held instruction SHALL be discarded, including mid-WAIT or mid-FULL.

Verification
REQ-031 Reset, send cond=0000 (EQ), S=0, out_ready=1 -> out_valid 2 cycles after transfer, out_exec=0 (Z=0), pending_cnt stays 0.
REQ-032 Send S=1 AL, then cond=0000: first issues, pending_cnt=1; second holds in WAIT until alu_flag_we=1 with alu_flags=0100, then out_exec=1 one cycle after; wait_cycles equals stall length.
REQ-033 MAX_PENDING=3, three S=1 AL issues without writeback -> pending_cnt=3; fourth S=1 AL stays in WAIT until one writeback, then pending_cnt returns to 3.
REQ-034 Issue and alu_flag_we same cycle with pending_cnt=1 -> pending_cnt=1, status=alu_flags; alu_flag_we with pending_cnt=0 -> flag_err=1.
REQ-035 Sweep all 16 cond values x 16 status values -> out_exec matches REQ-022 table; out_ready=0 for 3 cycles in FULL -> outputs stable, in_ready=0; rst mid-WAIT -> out_valid=0, pending_cnt=0 next cycle.
